// File: rtl/lsu_bus_ctrl.sv
// Load/store engine: one handshaked bus access per request, lane-aligned with byte enables, timeout and precise exceptions.
// Result strobe 1 cycle after ack (2-cycle min load-to-use); accepts only in IDLE/RESP, so back-to-back rate is one access per 2 cycles.
module lsu_bus_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [3:0]              op_i,
  input  logic [ADDR_WIDTH-1:0]   base_i,
  input  logic [ADDR_WIDTH-1:0]   offset_i,
  input  logic [DATA_WIDTH-1:0]   store_data_i,
  input  logic [4:0]              rd_i,
  input  logic                    flush_i,
  output logic                    bus_req_o,
  output logic                    bus_we_o,
  output logic [ADDR_WIDTH-1:0]   bus_addr_o,
  output logic [DATA_WIDTH/8-1:0] bus_be_o,
  output logic [DATA_WIDTH-1:0]   bus_wdata_o,
  input  logic                    bus_ack_i,
  input  logic                    bus_err_i,
  input  logic [DATA_WIDTH-1:0]   bus_rdata_i,
  output logic                    wb_valid_o,
  output logic [4:0]              wb_rd_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  output logic                    exc_valid_o,
  output logic [1:0]              exc_cause_o,
  output logic [ADDR_WIDTH-1:0]   exc_addr_o
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int LB    = $clog2(LANES);
  localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   ea_q;
  logic [3:0]              op_q;
  logic [4:0]              rd_q;
  logic                    load_q;
  logic                    kill_q;
  logic [CW-1:0]           wait_q;
  logic                    bus_req_q;
  logic                    bus_we_q;
  logic [ADDR_WIDTH-1:0]   bus_addr_q;
  logic [LANES-1:0]        bus_be_q;
  logic [DATA_WIDTH-1:0]   bus_wdata_q;
  logic                    wb_valid_q;
  logic [4:0]              wb_rd_q;
  logic [DATA_WIDTH-1:0]   wb_data_q;
  logic                    exc_valid_q;
  logic [1:0]              exc_cause_q;
  logic [ADDR_WIDTH-1:0]   exc_addr_q;

  logic [ADDR_WIDTH-1:0]   ea;
  logic [LB-1:0]           lane_new;
  logic                    is_load;
  logic                    is_store;
  logic [1:0]              size;
  logic                    misaligned;
  logic [LANES-1:0]        be_new;
  logic [DATA_WIDTH-1:0]   wdata_new;
  logic [DATA_WIDTH-1:0]   rd_shift;
  logic [DATA_WIDTH-1:0]   load_data;
  logic                    accept;
  logic                    timeout_hit;
  logic                    kill_now;

  assign req_ready_o = ((state_q == S_IDLE) || (state_q == S_RESP)) && !rst_i;
  assign accept      = req_valid_i && req_ready_o && !flush_i;
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == CW'(TIMEOUT - 1));
  assign kill_now    = kill_q || flush_i;

  always_comb begin
    ea       = base_i + offset_i;
    lane_new = ea[LB-1:0];
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = 2'd0;
    case (op_i)
      OP_LB, OP_LBU: begin is_load  = 1'b1; size = 2'd0; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; size = 2'd1; end
      OP_LW:         begin is_load  = 1'b1; size = 2'd2; end
      OP_SB:         begin is_store = 1'b1; size = 2'd0; end
      OP_SH:         begin is_store = 1'b1; size = 2'd1; end
      OP_SW:         begin is_store = 1'b1; size = 2'd2; end
      default:       ;
    endcase
    misaligned = ((size == 2'd1) && ea[0]) || ((size == 2'd2) && (ea[1:0] != 2'b00));
    case (size)
      2'd0: begin
        be_new    = LANES'(1) << lane_new;
        wdata_new = {LANES{store_data_i[7:0]}};
      end
      2'd1: begin
        be_new    = LANES'(3) << lane_new;
        wdata_new = {(LANES/2){store_data_i[15:0]}};
      end
      default: begin
        be_new    = LANES'(15) << lane_new;
        wdata_new = {(LANES/4){store_data_i[31:0]}};
      end
    endcase
  end

  // Selected lane is shifted down to bit 0, then extended per the latched op.
  always_comb begin
    rd_shift = bus_rdata_i >> {ea_q[LB-1:0], 3'b000};
    case (op_q)
      OP_LB:   load_data = DATA_WIDTH'($signed(rd_shift[7:0]));
      OP_LBU:  load_data = DATA_WIDTH'(rd_shift[7:0]);
      OP_LH:   load_data = DATA_WIDTH'($signed(rd_shift[15:0]));
      OP_LHU:  load_data = DATA_WIDTH'(rd_shift[15:0]);
      default: load_data = DATA_WIDTH'($signed(rd_shift[31:0]));
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ea_q        <= '0;
      op_q        <= OP_NOP;
      rd_q        <= '0;
      load_q      <= 1'b0;
      kill_q      <= 1'b0;
      wait_q      <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      exc_addr_q  <= '0;
    end else begin
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      exc_addr_q  <= '0;
      case (state_q)
        S_IDLE, S_RESP: begin
          state_q <= S_IDLE;
          if (accept) begin
            ea_q   <= ea;
            op_q   <= op_i;
            rd_q   <= rd_i;
            load_q <= is_load;
            kill_q <= 1'b0;
            wait_q <= '0;
            if ((is_load || is_store) && misaligned) begin
              state_q     <= S_RESP;
              exc_valid_q <= 1'b1;
              exc_cause_q <= is_store ? 2'd1 : 2'd0;
              exc_addr_q  <= ea;
            end else if (is_load || is_store) begin
              state_q     <= S_BUS;
              bus_req_q   <= 1'b1;
              bus_we_q    <= is_store;
              bus_addr_q  <= {ea[ADDR_WIDTH-1:LB], {LB{1'b0}}};
              bus_be_q    <= be_new;
              bus_wdata_q <= wdata_new;
            end
          end
        end
        S_BUS: begin
          // A flush never aborts the bus cycle; it only silences the response.
          if (flush_i) kill_q <= 1'b1;
          if (bus_err_i || bus_ack_i || timeout_hit) begin
            state_q     <= S_RESP;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            if (!kill_now) begin
              if (bus_err_i) begin
                exc_valid_q <= 1'b1;
                exc_cause_q <= 2'd2;
                exc_addr_q  <= ea_q;
              end else if (bus_ack_i) begin
                if (load_q) begin
                  wb_valid_q <= 1'b1;
                  wb_rd_q    <= rd_q;
                  wb_data_q  <= load_data;
                end
              end else begin
                exc_valid_q <= 1'b1;
                exc_cause_q <= 2'd3;
                exc_addr_q  <= ea_q;
              end
            end
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;

  // A flush arriving in the RESP cycle still squashes the registered strobe.
  assign wb_valid_o  = wb_valid_q && !flush_i;
  assign wb_rd_o     = wb_valid_o ? wb_rd_q : '0;
  assign wb_data_o   = wb_valid_o ? wb_data_q : '0;
  assign exc_valid_o = exc_valid_q && !flush_i;
  assign exc_cause_o = exc_valid_o ? exc_cause_q : '0;
  assign exc_addr_o  = exc_valid_o ? exc_addr_q : '0;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Bench for lsu_bus_ctrl: directed scenarios plus randomized accesses against a transaction-level model.
module tb_lsu_bus_ctrl;

  localparam int TO = 4;
  localparam logic [3:0] OP_NOP = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst, req_valid, req_ready, flush, bus_req, bus_we, bus_ack, bus_err;
  logic [3:0]  op, bus_be;
  logic [31:0] base, offset, store_data, bus_addr, bus_wdata, bus_rdata, wb_data, exc_addr;
  logic [4:0]  rd, wb_rd;
  logic        wb_valid, exc_valid;
  logic [1:0]  exc_cause;

  logic        w_rst, w_req_valid, w_req_ready, w_flush, w_bus_req, w_bus_we, w_bus_ack, w_bus_err;
  logic [3:0]  w_op;
  logic [7:0]  w_bus_be;
  logic [31:0] w_base, w_offset, w_bus_addr, w_exc_addr;
  logic [63:0] w_store_data, w_bus_wdata, w_bus_rdata, w_wb_data;
  logic [4:0]  w_rd, w_wb_rd;
  logic        w_wb_valid, w_exc_valid;
  logic [1:0]  w_exc_cause;

  lsu_bus_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready), .op_i(op),
    .base_i(base), .offset_i(offset), .store_data_i(store_data), .rd_i(rd), .flush_i(flush),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_be_o(bus_be),
    .bus_wdata_o(bus_wdata), .bus_ack_i(bus_ack), .bus_err_i(bus_err), .bus_rdata_i(bus_rdata),
    .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data), .exc_valid_o(exc_valid),
    .exc_cause_o(exc_cause), .exc_addr_o(exc_addr));

  lsu_bus_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT(TO)) dut64 (
    .clk_i(clk), .rst_i(w_rst), .req_valid_i(w_req_valid), .req_ready_o(w_req_ready), .op_i(w_op),
    .base_i(w_base), .offset_i(w_offset), .store_data_i(w_store_data), .rd_i(w_rd), .flush_i(w_flush),
    .bus_req_o(w_bus_req), .bus_we_o(w_bus_we), .bus_addr_o(w_bus_addr), .bus_be_o(w_bus_be),
    .bus_wdata_o(w_bus_wdata), .bus_ack_i(w_bus_ack), .bus_err_i(w_bus_err), .bus_rdata_i(w_bus_rdata),
    .wb_valid_o(w_wb_valid), .wb_rd_o(w_wb_rd), .wb_data_o(w_wb_data), .exc_valid_o(w_exc_valid),
    .exc_cause_o(w_exc_cause), .exc_addr_o(w_exc_addr));

  // Observations of one 32-bit transaction; bit i of each vector = cycle i after accept.
  logic [10:1] o_req, o_rdy, o_wbv, o_excv;
  logic [31:0] o_addr, o_wdata, o_wbdata, o_excaddr;
  logic [3:0]  o_be;
  logic        o_we, o_unstable, o_leak, o_acc_rdy;
  logic [4:0]  o_wbrd;
  logic [1:0]  o_cause;

  logic [10:1] e_req, e_rdy, e_wbv, e_excv;
  logic [31:0] e_addr, e_wdata, e_wbdata, e_excaddr;
  logic [3:0]  e_be;
  logic        e_we;
  logic [4:0]  e_wbrd;
  logic [1:0]  e_cause;

  task automatic drive32(input logic [3:0] t_op, input logic [31:0] t_base, t_off, t_sd, t_rdata,
                         input logic [4:0] t_rd, input int ack_at, err_at, flush_at);
    bit got;
    @(posedge clk); #1;
    req_valid = 1'b1; op = t_op; base = t_base; offset = t_off; store_data = t_sd; rd = t_rd;
    @(negedge clk);
    o_acc_rdy = req_ready;
    o_req = '0; o_rdy = '0; o_wbv = '0; o_excv = '0; o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0;
    o_wbdata = '0; o_wbrd = '0; o_cause = '0; o_excaddr = '0; o_unstable = 1'b0; o_leak = 1'b0;
    got = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; op = OP_NOP; base = '0; offset = '0; store_data = '0; rd = '0;
    for (int i = 1; i <= 10; i++) begin
      if (i > 1) begin @(posedge clk); #1; end
      bus_ack = (i == ack_at); bus_err = (i == err_at); flush = (i == flush_at); bus_rdata = t_rdata;
      @(negedge clk);
      o_req[i] = bus_req; o_rdy[i] = req_ready; o_wbv[i] = wb_valid; o_excv[i] = exc_valid;
      if (bus_req) begin
        if (!got) begin
          o_addr = bus_addr; o_be = bus_be; o_wdata = bus_wdata; o_we = bus_we; got = 1'b1;
        end else if ({bus_addr, bus_be, bus_wdata, bus_we} !== {o_addr, o_be, o_wdata, o_we}) begin
          o_unstable = 1'b1;
        end
      end
      if (wb_valid) begin o_wbdata = wb_data; o_wbrd = wb_rd; end
      else if ({wb_rd, wb_data} !== '0) o_leak = 1'b1;
      if (exc_valid) begin o_cause = exc_cause; o_excaddr = exc_addr; end
      else if ({exc_cause, exc_addr} !== '0) o_leak = 1'b1;
    end
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_err = 1'b0; flush = 1'b0;
  endtask

  // Transaction-level reference: which cycle ends the bus phase, what the bus sees, what comes back.
  task automatic model32(input logic [3:0] t_op, input logic [31:0] t_base, t_off, t_sd, t_rdata,
                         input logic [4:0] t_rd, input int ack_at, err_at, flush_at);
    logic [31:0] ea;
    logic [63:0] v;
    int n, lane, e;
    bit is_load, is_signed, killed;
    e_req = '0; e_rdy = '1; e_wbv = '0; e_excv = '0; e_addr = '0; e_wdata = '0; e_be = '0; e_we = 1'b0;
    e_wbdata = '0; e_wbrd = '0; e_cause = '0; e_excaddr = '0;
    ea = t_base + t_off;
    lane = int'(ea % 4);
    n = (t_op == OP_LB || t_op == OP_LBU || t_op == OP_SB) ? 1 :
        (t_op == OP_LH || t_op == OP_LHU || t_op == OP_SH) ? 2 :
        (t_op == OP_LW || t_op == OP_SW) ? 4 : 0;
    is_load = (t_op >= OP_LB) && (t_op <= OP_LHU);
    is_signed = (t_op == OP_LB) || (t_op == OP_LH) || (t_op == OP_LW);
    if (n == 0) return;
    if ((ea % n) != 0) begin
      if (flush_at != 1) begin e_excv[1] = 1'b1; e_cause = is_load ? 2'd0 : 2'd1; e_excaddr = ea; end
      return;
    end
    e = TO;
    if (ack_at >= 1 && ack_at <= e) e = ack_at;
    if (err_at >= 1 && err_at <= e) e = err_at;
    for (int i = 1; i <= e; i++) begin e_req[i] = 1'b1; e_rdy[i] = 1'b0; end
    e_addr = ea & ~32'd3;
    e_be = 4'(((1 << n) - 1) << lane);
    e_we = !is_load;
    for (int j = 0; j < 4; j++) e_wdata[8*j +: 8] = t_sd[8*(j % n) +: 8];
    killed = (flush_at >= 1) && (flush_at <= e + 1);
    if (killed) return;
    if (err_at == e || ack_at != e) begin
      e_excv[e+1] = 1'b1; e_cause = (err_at == e) ? 2'd2 : 2'd3; e_excaddr = ea;
    end else if (is_load) begin
      v = ({32'd0, t_rdata} >> (8 * lane)) & ((64'd1 << (8 * n)) - 64'd1);
      if (is_signed && v[8*n-1]) v = v - (64'd1 << (8 * n));
      e_wbv[e+1] = 1'b1; e_wbrd = t_rd; e_wbdata = v[31:0];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; w_rst = 1'b1;
    @(negedge clk);
    total++; if ({req_ready, w_req_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", {req_ready, w_req_ready}); end
    total++; if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, wb_valid, wb_rd, wb_data, exc_valid, exc_cause, exc_addr} !== '0) begin
      bad++; $display("FAIL reset_outputs32: nonzero output bus_req=%b wb_valid=%b exc_valid=%b, want all 0", bus_req, wb_valid, exc_valid); end
    total++; if ({w_bus_req, w_bus_addr, w_bus_be, w_bus_wdata, w_wb_valid, w_wb_data, w_exc_valid, w_exc_addr} !== '0) begin
      bad++; $display("FAIL reset_outputs64: nonzero output bus_req=%b wb_valid=%b, want all 0", w_bus_req, w_wb_valid); end
    @(posedge clk); #1; rst = 1'b0; w_rst = 1'b0;
    @(negedge clk);
    total++; if ({req_ready, w_req_ready} !== 2'b11) begin bad++; $display("FAIL post_reset_ready: got %b want 11", {req_ready, w_req_ready}); end
  endtask

  task automatic test_load_byte();
    logic [10:1] xv;
    drive32(OP_LB, 32'h100, 32'd3, 32'h0, 32'h80FF_FFFF, 5'd5, 3, 0, 0);
    total++; if (o_addr !== 32'h100) begin bad++; $display("FAIL lb_addr: got %h want 00000100", o_addr); end
    total++; if (o_be !== 4'b1000) begin bad++; $display("FAIL lb_be: got %b want 1000", o_be); end
    xv = '0; xv[4] = 1'b1;
    total++; if (o_wbv !== xv) begin bad++; $display("FAIL lb_wb_timing: got %b want %b", o_wbv, xv); end
    total++; if (o_wbdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_data: got %h want ffffff80", o_wbdata); end
    total++; if (o_wbrd !== 5'd5) begin bad++; $display("FAIL lb_rd: got %0d want 5", o_wbrd); end
    drive32(OP_LBU, 32'h100, 32'd3, 32'h0, 32'h80FF_FFFF, 5'd6, 3, 0, 0);
    total++; if (o_wbdata !== 32'h0000_0080) begin bad++; $display("FAIL lbu_data: got %h want 00000080", o_wbdata); end
  endtask

  task automatic test_store_half();
    drive32(OP_SH, 32'h200, 32'hFFFF_FFFE, 32'h1234_ABCD, 32'h0, 5'd1, 1, 0, 0);
    total++; if ({o_addr, o_be, o_we} !== {32'h1FC, 4'b1100, 1'b1}) begin
      bad++; $display("FAIL sh_bus: got addr=%h be=%b we=%b want addr=000001fc be=1100 we=1", o_addr, o_be, o_we); end
    total++; if (o_wdata !== 32'hABCD_ABCD) begin bad++; $display("FAIL sh_wdata: got %h want abcdabcd", o_wdata); end
    total++; if ({o_wbv, o_excv} !== '0) begin bad++; $display("FAIL sh_strobes: got wb=%b exc=%b want none", o_wbv, o_excv); end
  endtask

  task automatic test_misaligned();
    drive32(OP_LW, 32'h100, 32'd2, 32'h0, 32'h0, 5'd2, 0, 0, 0);
    total++; if (o_excv !== 10'b00_0000_0001) begin bad++; $display("FAIL lw_mis_timing: got %b want 0000000001", o_excv); end
    total++; if ({o_cause, o_excaddr} !== {2'd0, 32'h102}) begin
      bad++; $display("FAIL lw_mis_info: got cause=%0d addr=%h want cause=0 addr=00000102", o_cause, o_excaddr); end
    total++; if (o_req !== '0) begin bad++; $display("FAIL lw_mis_noreq: got %b want 0", o_req); end
    drive32(OP_SW, 32'h100, 32'd1, 32'h0, 32'h0, 5'd2, 0, 0, 0);
    total++; if ({o_cause, o_excaddr, o_excv[1]} !== {2'd1, 32'h101, 1'b1}) begin
      bad++; $display("FAIL sw_mis: got cause=%0d addr=%h v=%b want cause=1 addr=00000101 v=1", o_cause, o_excaddr, o_excv[1]); end
  endtask

  task automatic test_timeout();
    drive32(OP_LW, 32'h100, 32'd0, 32'h0, 32'h0, 5'd3, 0, 0, 0);
    total++; if (o_req !== 10'b00_0000_1111) begin bad++; $display("FAIL to_req_len: got %b want 0000001111", o_req); end
    total++; if ({o_excv, o_cause} !== {10'b00_0001_0000, 2'd3}) begin
      bad++; $display("FAIL to_cause: got exc=%b cause=%0d want exc=0000010000 cause=3", o_excv, o_cause); end
    drive32(OP_LW, 32'h100, 32'd0, 32'h0, 32'h0, 5'd3, 2, 2, 0);
    total++; if ({o_excv, o_cause, o_wbv} !== {10'b00_0000_0100, 2'd2, 10'b0}) begin
      bad++; $display("FAIL err_wins: got exc=%b cause=%0d wb=%b want exc=0000000100 cause=2 wb=0", o_excv, o_cause, o_wbv); end
  endtask

  task automatic test_flush();
    drive32(OP_LW, 32'h100, 32'd0, 32'h0, 32'h1234_5678, 5'd4, 4, 0, 1);
    total++; if (o_req !== 10'b00_0000_1111) begin bad++; $display("FAIL flush_bus_runs: got %b want 0000001111", o_req); end
    total++; if ({o_wbv, o_excv} !== '0) begin bad++; $display("FAIL flush_no_strobe: got wb=%b exc=%b want none", o_wbv, o_excv); end
    total++; if (o_rdy[5] !== 1'b1) begin bad++; $display("FAIL flush_resp_ready: got %b want 1", o_rdy[5]); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1; req_valid = 1'b1; op = OP_LW; base = 32'h40; offset = 32'd0; rd = 5'd3;
    @(posedge clk); #1; req_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1; bus_ack = 1'b0;
    req_valid = 1'b1; op = OP_LBU; base = 32'h40; offset = 32'd2; rd = 5'd7;
    @(negedge clk);
    total++; if ({req_ready, wb_valid, exc_valid} !== 3'b100) begin
      bad++; $display("FAIL b2b_resp: got ready/wb/exc=%b want 100", {req_ready, wb_valid, exc_valid}); end
    @(posedge clk); #1; req_valid = 1'b0; op = OP_NOP; bus_ack = 1'b1; bus_rdata = 32'h00AB_0000;
    @(negedge clk);
    total++; if ({bus_req, bus_be} !== {1'b1, 4'b0100}) begin
      bad++; $display("FAIL b2b_second_bus: got req=%b be=%b want req=1 be=0100", bus_req, bus_be); end
    @(posedge clk); #1; bus_ack = 1'b0;
    @(negedge clk);
    total++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd7, 32'h0000_00AB}) begin
      bad++; $display("FAIL b2b_second_wb: got v=%b rd=%0d data=%h want v=1 rd=7 data=000000ab", wb_valid, wb_rd, wb_data); end
  endtask

  task automatic test_wide();
    bit strobe_seen;
    @(posedge clk); #1; w_req_valid = 1'b1; w_op = OP_LHU; w_base = 32'h1000; w_offset = 32'd6; w_rd = 5'd9;
    @(posedge clk); #1; w_req_valid = 1'b0; w_bus_ack = 1'b1; w_bus_rdata = 64'hBEEF_0000_0000_0000;
    @(negedge clk);
    total++; if ({w_bus_req, w_bus_be, w_bus_addr} !== {1'b1, 8'hC0, 32'h1000}) begin
      bad++; $display("FAIL w_lhu_bus: got req=%b be=%h addr=%h want req=1 be=c0 addr=00001000", w_bus_req, w_bus_be, w_bus_addr); end
    @(posedge clk); #1; w_bus_ack = 1'b0;
    @(negedge clk);
    total++; if ({w_wb_valid, w_wb_data} !== {1'b1, 64'h0000_0000_0000_BEEF}) begin
      bad++; $display("FAIL w_lhu_data: got v=%b data=%h want v=1 data=000000000000beef", w_wb_valid, w_wb_data); end
    @(posedge clk); #1; w_req_valid = 1'b1; w_op = OP_LW; w_base = 32'h1000; w_offset = 32'd4;
    @(posedge clk); #1; w_req_valid = 1'b0; w_bus_ack = 1'b1; w_bus_rdata = 64'h8000_0001_0000_0000;
    @(negedge clk);
    total++; if (w_bus_be !== 8'hF0) begin bad++; $display("FAIL w_lw_be: got %h want f0", w_bus_be); end
    @(posedge clk); #1; w_bus_ack = 1'b0;
    @(negedge clk);
    total++; if (w_wb_data !== 64'hFFFF_FFFF_8000_0001) begin bad++; $display("FAIL w_lw_sext: got %h want ffffffff80000001", w_wb_data); end
    @(posedge clk); #1; w_req_valid = 1'b1; w_op = OP_LW; w_base = 32'h1000; w_offset = 32'd0;
    @(posedge clk); #1; w_req_valid = 1'b0;
    @(posedge clk); #1; w_rst = 1'b1;
    @(negedge clk);
    total++; if (w_req_ready !== 1'b0) begin bad++; $display("FAIL w_rst_ready_now: got %b want 0", w_req_ready); end
    @(posedge clk); #1; w_bus_ack = 1'b1;
    @(negedge clk);
    total++; if ({w_req_ready, w_bus_req, w_bus_we, w_bus_addr, w_bus_be, w_bus_wdata, w_wb_valid, w_wb_rd, w_wb_data,
                 w_exc_valid, w_exc_cause, w_exc_addr} !== '0) begin
      bad++; $display("FAIL w_rst_midbus: got ready=%b bus_req=%b be=%h want all outputs 0", w_req_ready, w_bus_req, w_bus_be); end
    @(posedge clk); #1; w_rst = 1'b0; w_bus_ack = 1'b0;
    strobe_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (w_wb_valid || w_exc_valid || w_bus_req) strobe_seen = 1'b1;
    end
    total++; if (strobe_seen !== 1'b0) begin bad++; $display("FAIL w_rst_no_resp: got activity=%b want 0", strobe_seen); end
  endtask

  task automatic test_random();
    logic [3:0]  t_op;
    logic [31:0] t_base, t_off, t_sd, t_rdata;
    logic [4:0]  t_rd;
    int ack_at, err_at, flush_at;
    for (int k = 0; k < 60; k++) begin
      t_op = 4'($urandom_range(0, 8));
      t_base = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 3));
      t_off = 32'($urandom_range(0, 11)) - 32'd4;
      t_sd = $urandom; t_rdata = $urandom; t_rd = 5'($urandom);
      ack_at = $urandom_range(0, 5);
      err_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      flush_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : 0;
      model32(t_op, t_base, t_off, t_sd, t_rdata, t_rd, ack_at, err_at, flush_at);
      drive32(t_op, t_base, t_off, t_sd, t_rdata, t_rd, ack_at, err_at, flush_at);
      total++; if ({o_req, o_rdy, o_wbv, o_excv} !== {e_req, e_rdy, e_wbv, e_excv}) begin
        bad++; $display("FAIL rnd%0d_timing op=%0d: got req=%b rdy=%b wb=%b exc=%b want req=%b rdy=%b wb=%b exc=%b",
                        k, t_op, o_req, o_rdy, o_wbv, o_excv, e_req, e_rdy, e_wbv, e_excv); end
      total++; if ({o_addr, o_be, o_wdata, o_we} !== {e_addr, e_be, e_wdata, e_we}) begin
        bad++; $display("FAIL rnd%0d_bus op=%0d: got addr=%h be=%b wd=%h we=%b want addr=%h be=%b wd=%h we=%b",
                        k, t_op, o_addr, o_be, o_wdata, o_we, e_addr, e_be, e_wdata, e_we); end
      total++; if ({o_wbdata, o_wbrd} !== {e_wbdata, e_wbrd}) begin
        bad++; $display("FAIL rnd%0d_wb op=%0d: got data=%h rd=%0d want data=%h rd=%0d", k, t_op, o_wbdata, o_wbrd, e_wbdata, e_wbrd); end
      total++; if ({o_cause, o_excaddr} !== {e_cause, e_excaddr}) begin
        bad++; $display("FAIL rnd%0d_exc op=%0d: got cause=%0d addr=%h want cause=%0d addr=%h", k, t_op, o_cause, o_excaddr, e_cause, e_excaddr); end
      total++; if ({o_unstable, o_leak, o_acc_rdy} !== 3'b001) begin
        bad++; $display("FAIL rnd%0d_hygiene: got unstable/leak/ready=%b want 001", k, {o_unstable, o_leak, o_acc_rdy}); end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; op = OP_NOP; base = '0; offset = '0; store_data = '0; rd = '0;
    flush = 1'b0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    w_rst = 1'b1; w_req_valid = 1'b0; w_op = OP_NOP; w_base = '0; w_offset = '0; w_store_data = '0; w_rd = '0;
    w_flush = 1'b0; w_bus_ack = 1'b0; w_bus_err = 1'b0; w_bus_rdata = '0;
    test_reset();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_timeout();
    test_flush();
    test_back_to_back();
    test_wide();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
